// File: rtl/painel_sequenciador.sv
// painel_sequenciador: command sequencer for the panel's 16-bit load/rotate register.
// Loads a latched message once, then issues single-cycle rotate commands at a fixed
// step rate so the message scrolls across the seven-segment display.
module painel_sequenciador #(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned STEP_DIV  = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        dir,
  input  logic [4:0]  steps,
  input  logic [15:0] message,
  output logic        ch1,
  output logic        ch0,
  output logic [15:0] cadeiaDeBits,
  output logic        busy,
  output logic        done,
  output logic        step_pulse,
  output logic [3:0]  pos
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StPause,
    StDone
  } stateT;

  // Register mode encodings
  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  // Divider value shown during a step cycle, and the value one cycle before it.
  // Outputs are registered, so the step is decided on the edge that moves the
  // divider from PreLast to Last.
  localparam logic [DIV_WIDTH-1:0] LastCount = DIV_WIDTH'(STEP_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] PreLast   = DIV_WIDTH'(STEP_DIV - 2);

  stateT                state;
  logic [DIV_WIDTH-1:0] divider;
  logic [4:0]           stepCount;
  logic [4:0]           stepsLatched;
  logic                 dirLatched;
  logic [1:0]           mode;

  assign ch1 = mode[1];
  assign ch0 = mode[0];

  // Whole sequencer: state, divider, counters and every registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      mode         <= ModeHold;
      cadeiaDeBits <= 16'h0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_pulse   <= 1'b0;
      pos          <= 4'd0;
      divider      <= '0;
      stepCount    <= 5'd0;
      stepsLatched <= 5'd0;
      dirLatched   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below
      step_pulse <= 1'b0;
      done       <= 1'b0;

      case (state)
        StIdle: begin
          mode <= ModeHold;
          busy <= 1'b0;
          if (start) begin
            state        <= StLoad;
            mode         <= ModeLoad;
            busy         <= 1'b1;
            cadeiaDeBits <= message;
            dirLatched   <= dir;
            stepsLatched <= steps;
            divider      <= '0;
            pos          <= 4'd0;
            stepCount    <= 5'd0;
          end
        end

        StLoad: begin
          mode <= ModeHold;
          if (stop) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            state <= StRun;
          end
        end

        StRun: begin
          mode <= ModeHold;
          if (stop) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (stepsLatched != 5'd0 && stepCount == stepsLatched) begin
            // Final step was issued last cycle
            state <= StDone;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            divider <= (divider == LastCount) ? '0 : divider + DIV_WIDTH'(1);
            if (pause) begin
              // A due step is held back; divider parks on LastCount so the
              // step fires on release
              state <= StPause;
            end else if (divider == PreLast) begin
              mode       <= dirLatched ? ModeRight : ModeLeft;
              step_pulse <= 1'b1;
              pos        <= dirLatched ? pos - 4'd1 : pos + 4'd1;
              stepCount  <= stepCount + 5'd1;
            end
          end
        end

        StPause: begin
          mode <= ModeHold;
          if (stop) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (!pause) begin
            state <= StRun;
            if (divider == LastCount) begin
              // Deferred step; divider stays on LastCount for this step cycle
              mode       <= dirLatched ? ModeRight : ModeLeft;
              step_pulse <= 1'b1;
              pos        <= dirLatched ? pos - 4'd1 : pos + 4'd1;
              stepCount  <= stepCount + 5'd1;
            end
          end
        end

        StDone: begin
          state <= StIdle;
          mode  <= ModeHold;
          busy  <= 1'b0;
        end

        default: begin
          state <= StIdle;
          mode  <= ModeHold;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_painel_sequenciador.sv
// Directed self-checking bench for painel_sequenciador with a short step period.
module tb_painel_sequenciador;

  localparam int unsigned StepDiv = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        pause;
  logic        dir;
  logic [4:0]  steps;
  logic [15:0] message;
  logic        ch1;
  logic        ch0;
  logic [15:0] cadeiaDeBits;
  logic        busy;
  logic        done;
  logic        step_pulse;
  logic [3:0]  pos;

  int checks = 0;
  int errors = 0;

  painel_sequenciador #(
    .DIV_WIDTH(24),
    .STEP_DIV (StepDiv)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .dir         (dir),
    .steps       (steps),
    .message     (message),
    .ch1         (ch1),
    .ch0         (ch0),
    .cadeiaDeBits(cadeiaDeBits),
    .busy        (busy),
    .done        (done),
    .step_pulse  (step_pulse),
    .pos         (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, "_mode"}, 32'({ch1, ch0}), 32'd0);
    checkEq({tag, "_busy"}, 32'(busy), 32'd0);
    checkEq({tag, "_done"}, 32'(done), 32'd0);
    checkEq({tag, "_step"}, 32'(step_pulse), 32'd0);
  endtask

  // Request a run and check the single load cycle
  task automatic startRun(input logic [15:0] msg, input logic d, input logic [4:0] st);
    start   = 1'b1;
    message = msg;
    dir     = d;
    steps   = st;
    tick();
    checkEq("load_mode", 32'({ch1, ch0}), 32'd3);
    checkEq("load_data", 32'(cadeiaDeBits), 32'(msg));
    checkEq("load_busy", 32'(busy), 32'd1);
    checkEq("load_pos", 32'(pos), 32'd0);
    start = 1'b0;
  endtask

  // StepDiv-1 hold cycles followed by one rotate cycle
  task automatic waitStep(input logic [3:0] expPos, input logic [1:0] expMode);
    for (int i = 0; i < int'(StepDiv) - 1; i++) begin
      tick();
      checkEq("gap_mode", 32'({ch1, ch0}), 32'd0);
      checkEq("gap_pulse", 32'(step_pulse), 32'd0);
    end
    tick();
    checkEq("step_mode", 32'({ch1, ch0}), 32'(expMode));
    checkEq("step_pulse", 32'(step_pulse), 32'd1);
    checkEq("step_pos", 32'(pos), 32'(expPos));
    checkEq("step_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    pause   = 1'b0;
    dir     = 1'b0;
    steps   = 5'd0;
    message = 16'h0000;
    repeat (2) tick();
    checkIdle("reset");
    checkEq("reset_data", 32'(cadeiaDeBits), 32'd0);
    checkEq("reset_pos", 32'(pos), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset while a left rotate is on the mode pins
    startRun(16'h00FF, 1'b0, 5'd0);
    waitStep(4'd1, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    checkIdle("async_rst");
    checkEq("async_rst_data", 32'(cadeiaDeBits), 32'd0);
    checkEq("async_rst_pos", 32'(pos), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkIdle("post_rst");
    end

    // Finite left run of three steps
    startRun(16'hA5C3, 1'b0, 5'd3);
    for (int s = 1; s <= 3; s++) waitStep(4'(s), 2'b10);
    tick();
    checkEq("done_pulse", 32'(done), 32'd1);
    checkEq("done_busy", 32'(busy), 32'd0);
    checkEq("done_mode", 32'({ch1, ch0}), 32'd0);
    tick();
    checkIdle("after_done");
    checkEq("retain_data", 32'(cadeiaDeBits), 32'hA5C3);

    // Continuous right run, 17 steps, then stop
    startRun(16'h1357, 1'b1, 5'd0);
    for (int s = 1; s <= 17; s++) waitStep(4'((16 - s) % 16), 2'b01);
    stop = 1'b1;
    tick();
    checkIdle("cont_stop");
    stop = 1'b0;

    // Pause raised on the edge a step is due, held 10 cycles
    startRun(16'h0F0F, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("pre_pause_mode", 32'({ch1, ch0}), 32'd0);
    end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkEq("pause_mode", 32'({ch1, ch0}), 32'd0);
      checkEq("pause_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    tick();
    checkEq("resume_mode", 32'({ch1, ch0}), 32'd2);
    checkEq("resume_pulse", 32'(step_pulse), 32'd1);
    checkEq("resume_pos", 32'(pos), 32'd1);
    waitStep(4'd2, 2'b10);
    stop = 1'b1;
    tick();
    checkIdle("pause_stop");
    stop = 1'b0;

    // Stop on the edge the final step is due
    startRun(16'h1111, 1'b0, 5'd2);
    waitStep(4'd1, 2'b10);
    for (int i = 0; i < 3; i++) tick();
    stop = 1'b1;
    tick();
    checkIdle("stop_final");
    checkEq("stop_final_pos", 32'(pos), 32'd1);
    stop = 1'b0;
    tick();
    checkIdle("stop_final_next");

    // Start pulsed mid-run with a new message is ignored
    startRun(16'h1234, 1'b1, 5'd3);
    tick();
    start   = 1'b1;
    message = 16'hFFFF;
    tick();
    checkEq("restart_mode", 32'({ch1, ch0}), 32'd0);
    checkEq("restart_data", 32'(cadeiaDeBits), 32'h1234);
    start = 1'b0;
    tick();
    tick();
    checkEq("restart_step_mode", 32'({ch1, ch0}), 32'd1);
    checkEq("restart_step_pos", 32'(pos), 32'd15);
    waitStep(4'd14, 2'b01);
    waitStep(4'd13, 2'b01);
    tick();
    checkEq("restart_done", 32'(done), 32'd1);
    checkEq("restart_data_end", 32'(cadeiaDeBits), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/painel_sequenciador.md
# painel_sequenciador

Command sequencer that drives the 16-bit universal (load/rotate) register behind the electronic panel's seven-segment display. It latches a 16-bit message and issues one parallel-load command. It then issues single-cycle rotate commands at a programmable step rate, so the message scrolls across the display. It sits between the panel's user controls and the register, owning the register's mode pins (`ch1`, `ch0`) and its parallel data bus.

## Interface
- `DIV_WIDTH`, 24: width of the step-rate divider counter.
- `STEP_DIV`, 12500000: clock cycles per scroll step (4 steps/s at 50 MHz); legal range 2..2^DIV_WIDTH-1.

- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled request to begin a run.
- `stop` in 1: abort the run and return to idle.
- `pause` in 1: freeze scrolling while high.
- `dir` in 1: scroll direction, latched at start (0 = left, 1 = right).
- `steps` in 5: number of rotate steps per run, latched at start; 0 = continuous.
- `message` in 16: pattern to load, latched at start.
- `ch1`, `ch0` out 1 each: register mode, 00 hold, 01 rotate right, 10 rotate left, 11 parallel load.
- `cadeiaDeBits` out 16: parallel-load data to the register.
- `busy` out 1: high in LOAD, RUN and PAUSE.
- `done` out 1: one-cycle pulse when a finite run completes.
- `step_pulse` out 1: high in exactly the cycle a rotate command is issued.
- `pos` out 4: current rotation offset of the displayed message, mod 16.

## Operation
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - mode 00, `busy` 0.
  - `start`=1 moves to LOAD and latches `message` into `cadeiaDeBits`, plus `dir` and `steps`.
- LOAD, one cycle:
  - mode 11, `busy` 1.
  - Divider cleared to 0, `pos` cleared to 0, step count cleared to 0.
  - Always moves to RUN.
- RUN:
  - Divider increments every cycle; mode is 00 except on step cycles.
  - Step cycle: when the divider equals `STEP_DIV`-1, the divider wraps to 0.
  - In that cycle the mode is 10 if `dir`=0, else 01, and `step_pulse`=1.
  - `pos` is +1 for left or -1 for right, wrapping mod 16 (15+1 → 0, 0-1 → 15).
  - Step count increments; when `steps`≠0 and the new count equals `steps`, next state is DONE.
- PAUSE:
  - Entered from RUN when `pause`=1.
  - Mode 00; divider, `pos` and step count are frozen.
  - Returns to RUN when `pause`=0; the divider resumes from its frozen value.
- DONE, one cycle: mode 00, `done`=1, `busy`=0, then IDLE. `cadeiaDeBits` retains the last message.
- Priority when events coincide: `stop` > step completion > `pause`.
  - `stop` in any non-IDLE state goes to IDLE next cycle with mode 00. No `done`, and no step issues in that cycle.
  - `pause` and a due step in the same cycle: the step is not issued; the divider holds at `STEP_DIV`-1, and the step issues on the first cycle after `pause` falls.
- `start` while `busy` is ignored. `message`, `dir` and `steps` changes mid-run are ignored.
- `start` held high through DONE restarts: IDLE samples it and loads again.
- Continuous mode (`steps`=0) never reaches DONE; only `stop` ends the run.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE; {`ch1`,`ch0`}=00; `cadeiaDeBits`=0; `busy`, `done`, `step_pulse`=0; `pos`=0; divider and count 0.
- Reset mid-run forces these values immediately; no command is issued after release until a new `start`.
- Let `start` be sampled on edge E0.
  - Mode 11 and `busy`=1 are visible in cycle E0..E1.
  - The first rotate command is visible `STEP_DIV` cycles after LOAD. With `STEP_DIV`=4, it is in the 5th cycle after E0.
- Steps are spaced exactly `STEP_DIV` cycles apart when unpaused.
- `done` follows the final step cycle by one cycle. `busy` falls in the same cycle `done` rises.
- `stop` sampled at edge E: outputs show idle values from E onward.

## Test plan
- Reset while RUN with mode 10 active → all outputs 0 immediately, and they stay 0 after release with `start`=0.
- `STEP_DIV`=4, `message`=16'hA5C3, `dir`=0, `steps`=3:
  - Expect one cycle of mode 11 with `cadeiaDeBits`=16'hA5C3.
  - Then mode 10 pulses 4 cycles apart, with `pos` 1, 2, 3.
  - Then `done` for one cycle and `busy` 0.
- `dir`=1, `steps`=0, `STEP_DIV`=4, 17 steps → `pos` sequence 15, 14, …, 0, 15; no `done`; `stop` returns to IDLE next cycle with mode 00.
- `pause` asserted in the cycle a step is due, held 10 cycles → no mode 01/10 during the pause; the step issues in the first cycle after `pause` falls; subsequent spacing is 4.
- `stop` and the final step due in the same cycle (`steps`=2) → no rotate command, no `done`, and IDLE next cycle.
- `start` pulsed mid-run with a new `message`=16'hFFFF → ignored: no second mode 11, `cadeiaDeBits` unchanged, step timing undisturbed.
